jtframe_spi_dwnld_rx: RTL and testbench

//  Core-side receiver for the MiST SPI download protocol on SPI_SS2: the

---
 rtl/jtframe_spi_dwnld_rx.sv | 175 +++++++++++++++++
 tb/tb_jtframe_spi_dwnld_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_spi_dwnld_rx.sv
// Core-side receiver for the MiST SPI download protocol on SPI_SS2.
// SCK/SS2/DI are oversampled in the core clock and decoded into
// byte-wide ioctl writes with an auto-incrementing address.
// Optional feature macro: JTFRAME_DWNLD_CHKSUM_EN (running 16-bit byte sum).
module jtframe_spi_dwnld_rx #(
  parameter int AW   = 25,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SPI_SCK,
  input  logic          SPI_SS2,
  input  logic          SPI_DI,
  output logic          downloading,
  output logic [7:0]    ioctl_index,
  output logic [AW-1:0] ioctl_addr,
  output logic [7:0]    ioctl_data,
  output logic          ioctl_wr,
  output logic [15:0]   chksum
);

  localparam logic [7:0]    CMD_TXCTL = 8'h53;
  localparam logic [7:0]    CMD_DATA  = 8'h54;
  localparam logic [7:0]    CMD_INDEX = 8'h55;
  localparam logic [7:0]    TX_START  = 8'hFF;
  localparam logic [7:0]    TX_END    = 8'h00;
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_TXCTL  = 3'd1,
    ST_DATA   = 3'd2,
    ST_INDEX  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t          state_r;
  logic [SYNC-1:0] sck_sync_r;
  logic [SYNC-1:0] ss2_sync_r;
  logic [SYNC-1:0] di_sync_r;
  logic            sck_prev_r;
  logic            armed_r;
  logic [2:0]      bit_cnt_r;
  logic [6:0]      shift_r;
  logic [7:0]      byte_r;
  logic            byte_done_r;
  logic            sck_s;
  logic            ss2_s;
  logic            di_s;
  logic            sck_rise_s;
  logic            start_s;

  assign sck_s = sck_sync_r[SYNC-1];
  assign ss2_s = ss2_sync_r[SYNC-1];
  assign di_s  = di_sync_r[SYNC-1];

  // Bytes are only accepted once SS2 has been seen high since reset,
  // so a frame interrupted by reset is discarded until the next frame.
  assign sck_rise_s = sck_s & ~sck_prev_r & ~ss2_s & armed_r;
  assign start_s    = byte_done_r & (state_r == ST_TXCTL) & (byte_r == TX_START);

  // Synchronisers for the asynchronous SPI pins (SS2 resets low so that
  // reset release alone never arms the receiver).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r <= {SYNC{1'b0}};
      ss2_sync_r <= {SYNC{1'b0}};
      di_sync_r  <= {SYNC{1'b0}};
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC-2:0], SPI_SCK};
      ss2_sync_r <= {ss2_sync_r[SYNC-2:0], SPI_SS2};
      di_sync_r  <= {di_sync_r[SYNC-2:0], SPI_DI};
    end
  end

  // Bit engine: shifts DI in MSB first on SCK rise, flags each full byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_prev_r  <= 1'b0;
      armed_r     <= 1'b0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 7'd0;
      byte_r      <= 8'd0;
      byte_done_r <= 1'b0;
    end else begin
      sck_prev_r  <= sck_s;
      byte_done_r <= 1'b0;
      if (ss2_s) begin
        bit_cnt_r <= 3'd0;
        armed_r   <= 1'b1;
      end else if (sck_rise_s) begin
        shift_r   <= {shift_r[5:0], di_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_r      <= {shift_r, di_s};
          byte_done_r <= 1'b1;
        end
      end
    end
  end

  // Command FSM with registered ioctl outputs; the address advances on the
  // clock after each strobe so the strobe carries the target address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_CMD;
      downloading <= 1'b0;
      ioctl_index <= 8'd0;
      ioctl_addr  <= {AW{1'b0}};
      ioctl_data  <= 8'd0;
      ioctl_wr    <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      if (ioctl_wr) begin
        ioctl_addr <= ioctl_addr + ADDR_ONE;
      end
      if (byte_done_r) begin
        case (state_r)
          ST_CMD: begin
            case (byte_r)
              CMD_TXCTL: state_r <= ST_TXCTL;
              CMD_DATA:  state_r <= ST_DATA;
              CMD_INDEX: state_r <= ST_INDEX;
              default:   state_r <= ST_IGNORE;
            endcase
          end
          ST_TXCTL: begin
            if (start_s) begin
              downloading <= 1'b1;
              ioctl_addr  <= {AW{1'b0}};
            end else if (byte_r == TX_END) begin
              downloading <= 1'b0;
            end
            state_r <= ST_IGNORE;
          end
          ST_INDEX: begin
            ioctl_index <= byte_r;
            state_r     <= ST_IGNORE;
          end
          ST_DATA: begin
            if (downloading) begin
              ioctl_data <= byte_r;
              ioctl_wr   <= 1'b1;
            end
          end
          ST_IGNORE: state_r <= ST_IGNORE;
          default:   state_r <= ST_IGNORE;
        endcase
      end
      if (ss2_s) begin
        state_r <= ST_CMD;
      end
    end
  end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
  logic [15:0] chksum_r;

  assign chksum = chksum_r;

  // Running modulo-2^16 sum of every written byte, cleared on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum_r <= 16'd0;
    end else if (start_s) begin
      chksum_r <= 16'd0;
    end else if (ioctl_wr) begin
      chksum_r <= chksum_r + {8'd0, ioctl_data};
    end
  end
`else
  assign chksum = 16'd0;
`endif

endmodule

// File: tb/tb_jtframe_spi_dwnld_rx.sv
// Directed bench for jtframe_spi_dwnld_rx (AW=4 to reach address wrap).
module tb_jtframe_spi_dwnld_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SPI_SCK = 1'b0;
  logic        SPI_SS2 = 1'b1;
  logic        SPI_DI = 1'b0;
  logic        downloading;
  logic [7:0]  ioctl_index;
  logic [3:0]  ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [15:0] chksum;

  int          total = 0;
  int          bad = 0;
  int          long_strobe = 0;
  logic        prev_wr = 1'b0;
  logic [11:0] wq[$];

  jtframe_spi_dwnld_rx #(.AW(4), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
    .downloading(downloading), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .chksum(chksum)
  );

  always #5 clk = ~clk;

  // Write logger and strobe-width watch, sampled away from the active edge.
  always @(negedge clk) begin
    if (ioctl_wr) wq.push_back({ioctl_addr, ioctl_data});
    if (ioctl_wr && prev_wr) long_strobe++;
    prev_wr = ioctl_wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      SPI_DI = b[i];
      #40 SPI_SCK = 1'b1;
      #40 SPI_SCK = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic frame_begin;
    SPI_SS2 = 1'b0;
    #40;
  endtask

  task automatic frame_end;
    #40 SPI_SS2 = 1'b1;
    #100;
  endtask

  task automatic frame2(input logic [7:0] a, input logic [7:0] b);
    frame_begin();
    spi_byte(a);
    spi_byte(b);
    frame_end();
  endtask

  initial begin
    #23 rst = 1'b0;
    #100;
    check("rst_dl",   downloading, 0);
    check("rst_idx",  ioctl_index, 0);
    check("rst_addr", ioctl_addr, 0);
    check("rst_data", ioctl_data, 0);
    check("rst_wr",   ioctl_wr, 0);
    check("rst_sum",  chksum, 0);

    // 1: start then three data bytes
    frame2(8'h53, 8'hFF);
    check("t1_dl", downloading, 1);
    wq.delete();
    frame_begin();
    spi_byte(8'h54); spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'h56);
    frame_end();
    check("t1_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      check("t1_w0", wq[0], {4'h0, 8'h12});
      check("t1_w1", wq[1], {4'h1, 8'h34});
      check("t1_w2", wq[2], {4'h2, 8'h56});
    end
    check("t1_addr", ioctl_addr, 3);

    // 2: end then a data frame is dropped
    frame2(8'h53, 8'h00);
    check("t2_dl", downloading, 0);
    wq.delete();
    frame2(8'h54, 8'hAA);
    check("t2_nwr",  wq.size(), 0);
    check("t2_hold", {ioctl_addr, ioctl_data}, {4'h3, 8'h56});

    // 3: index command
    frame2(8'h55, 8'h05);
    check("t3_idx", ioctl_index, 8'h05);
    check("t3_nwr", wq.size(), 0);
    check("t3_dl",  downloading, 0);

    // 4: address wrap after 2**AW-1
    frame2(8'h53, 8'hFF);
    wq.delete();
    frame_begin();
    spi_byte(8'h54);
    for (int k = 0; k < 17; k++) spi_byte(8'h20 + 8'(k));
    frame_end();
    check("t4_nwr", wq.size(), 17);
    if (wq.size() == 17) begin
      check("t4_w15", wq[15], {4'hF, 8'h2F});
      check("t4_w16", wq[16], {4'h0, 8'h30});
    end
    check("t4_dl", downloading, 1);

    // 5: SS2 raised after 5 bits never writes
    wq.delete();
    frame_begin();
    spi_byte(8'h54);
    spi_bits(8'hC3, 5);
    frame_end();
    check("t5_nwr", wq.size(), 0);
    frame2(8'h54, 8'h77);
    check("t5_nwr2", wq.size(), 1);
    if (wq.size() == 1) check("t5_w", wq[0], {4'h1, 8'h77});

    // 6: checksum over FF,FF,03
    frame2(8'h53, 8'hFF);
    frame_begin();
    spi_byte(8'h54); spi_byte(8'hFF); spi_byte(8'hFF); spi_byte(8'h03);
    frame_end();
    frame2(8'h53, 8'h00);
`ifdef JTFRAME_DWNLD_CHKSUM_EN
    check("t6_sum", chksum, 16'h0201);
`else
    check("t6_sum", chksum, 16'h0000);
`endif
    check("t6_dl", downloading, 0);

    // Reset pulse mid-byte while downloading
    frame2(8'h53, 8'hFF);
    wq.delete();
    frame_begin();
    spi_byte(8'h54);
    spi_byte(8'h11);
    spi_bits(8'hA5, 3);
    check("r_pre_dl", downloading, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("r_dl",   downloading, 0);
    check("r_idx",  ioctl_index, 0);
    check("r_addr", ioctl_addr, 0);
    check("r_data", ioctl_data, 0);
    check("r_sum",  chksum, 0);
    #20 rst = 1'b0;
    wq.delete();
    spi_bits(8'hA5, 5);
    spi_byte(8'h99);
    frame_end();
    check("r_nwr", wq.size(), 0);
    frame2(8'h53, 8'hFF);
    frame2(8'h54, 8'h42);
    check("r_nwr2", wq.size(), 1);
    if (wq.size() == 1) check("r_w", wq[0], {4'h0, 8'h42});

    check("strobe_len", long_strobe, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
